branch_fwd_ctrl: RTL and testbench

//  Producer of the 4-bit forward-select code consumed by the D-stage branch-operand forwarding mux.

---
 rtl/branch_fwd_pkg.sv | 40 ++++
 rtl/branch_fwd_ctrl_if.sv | 27 ++
 rtl/fwd_src_sel.sv | 25 ++
 rtl/branch_fwd_ctrl.sv | 135 +++++++++++++
 tb/tb_branch_fwd_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/branch_fwd_pkg.sv
// Shared types for the branch-operand forwarding controller: forward-select
// codes, per-operand source selection, and the tracked pipeline stage record.
package branch_fwd_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned CODE_W = 4;

  // Forward-select code driven to the D-stage branch mux, named {A,B}
  // (R = register file, M = memory stage, W = writeback stage).
  typedef enum logic [CODE_W-1:0] {
    FWD_NONE  = 4'd0,
    FWD_MA_MB = 4'd1,
    FWD_WA_WB = 4'd2,
    FWD_MA_RB = 4'd3,
    FWD_RA_MB = 4'd4,
    FWD_WA_RB = 4'd5,
    FWD_RA_WB = 4'd8,
    FWD_WA_MB = 4'd9,
    FWD_MA_WB = 4'd10
  } fwd_code_e;

  typedef enum logic [1:0] {
    SRC_REG = 2'd0,
    SRC_MEM = 2'd1,
    SRC_WB  = 2'd2
  } fwd_src_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } stage_info_t;

  // A stage produces register r when it holds a valid writer of r; x0 never counts.
  function automatic logic stage_writes(stage_info_t s, logic [REG_AW-1:0] r);
    return s.valid & s.regwrite & (s.rd == r) & (r != '0);
  endfunction

endpackage

// File: rtl/branch_fwd_ctrl_if.sv
// D-stage request / forward-select response bundle of branch_fwd_ctrl.
interface branch_fwd_ctrl_if;

  logic                                   flush_i;
  logic                                   id_valid_i;
  logic                                   id_branch_i;
  logic [branch_fwd_pkg::REG_AW-1:0]      id_rs1_i;
  logic [branch_fwd_pkg::REG_AW-1:0]      id_rs2_i;
  logic [branch_fwd_pkg::REG_AW-1:0]      id_rd_i;
  logic                                   id_regwrite_i;
  logic                                   id_memread_i;
  logic [branch_fwd_pkg::CODE_W-1:0]      opforward_o;
  logic                                   stall_o;

  modport master (
    output flush_i, id_valid_i, id_branch_i, id_rs1_i, id_rs2_i, id_rd_i,
           id_regwrite_i, id_memread_i,
    input  opforward_o, stall_o
  );

  modport slave (
    input  flush_i, id_valid_i, id_branch_i, id_rs1_i, id_rs2_i, id_rd_i,
           id_regwrite_i, id_memread_i,
    output opforward_o, stall_o
  );

endinterface

// File: rtl/fwd_src_sel.sv
// Per-operand forwarding source: M (non-load) beats W, otherwise register file.
module fwd_src_sel
  import branch_fwd_pkg::*;
(
  input  logic [REG_AW-1:0] rs_i,
  input  stage_info_t       m_i,
  input  stage_info_t       w_i,
  output fwd_src_e          src_o
);

  // W's load flag is irrelevant: its data is already available.
  logic unused_w_memread;
  assign unused_w_memread = w_i.memread;

  // Youngest forwardable producer wins.
  always_comb begin
    src_o = SRC_REG;
    if (stage_writes(m_i, rs_i) && !m_i.memread) begin
      src_o = SRC_MEM;
    end else if (stage_writes(w_i, rs_i)) begin
      src_o = SRC_WB;
    end
  end

endmodule

// File: rtl/branch_fwd_ctrl.sv
// Branch-operand forwarding / stall controller for the D stage.
// Tracks EX/M/W destinations, stalls D on unresolvable RAW hazards and
// otherwise drives the forward-select code for the branch mux.
// Optional: define BRANCH_FWD_STATS_EN for stall_cnt_o / fwd_cnt_o counters.
module branch_fwd_ctrl
  import branch_fwd_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  branch_fwd_ctrl_if.slave bus
`ifdef BRANCH_FWD_STATS_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] fwd_cnt_o
`endif
);

  stage_info_t ex_d, ex_q;
  stage_info_t m_d,  m_q;
  stage_info_t w_d,  w_q;

  logic      is_branch;
  logic      stall;
  fwd_src_e  src_a, src_b;
  fwd_code_e code;

  assign is_branch = bus.id_valid_i & bus.id_branch_i;

  // Stall when EX produces an operand, or M holds a load producing one.
  always_comb begin
    stall = 1'b0;
    if (is_branch) begin
      if (stage_writes(ex_q, bus.id_rs1_i) || stage_writes(ex_q, bus.id_rs2_i)) begin
        stall = 1'b1;
      end
      if (m_q.memread &&
          (stage_writes(m_q, bus.id_rs1_i) || stage_writes(m_q, bus.id_rs2_i))) begin
        stall = 1'b1;
      end
    end
  end

  fwd_src_sel u_sel_a (
    .rs_i  (bus.id_rs1_i),
    .m_i   (m_q),
    .w_i   (w_q),
    .src_o (src_a)
  );

  fwd_src_sel u_sel_b (
    .rs_i  (bus.id_rs2_i),
    .m_i   (m_q),
    .w_i   (w_q),
    .src_o (src_b)
  );

  // Encode the per-operand sources into the mux select code.
  always_comb begin
    code = FWD_NONE;
    if (is_branch && !stall) begin
      case ({src_a, src_b})
        {SRC_MEM, SRC_MEM}: code = FWD_MA_MB;
        {SRC_WB,  SRC_WB }: code = FWD_WA_WB;
        {SRC_MEM, SRC_REG}: code = FWD_MA_RB;
        {SRC_REG, SRC_MEM}: code = FWD_RA_MB;
        {SRC_WB,  SRC_REG}: code = FWD_WA_RB;
        {SRC_REG, SRC_WB }: code = FWD_RA_WB;
        {SRC_WB,  SRC_MEM}: code = FWD_WA_MB;
        {SRC_MEM, SRC_WB }: code = FWD_MA_WB;
        default:            code = FWD_NONE;
      endcase
    end
  end

  assign bus.stall_o     = stall;
  assign bus.opforward_o = code;

  // Next tracking-pipe contents; a stalled or flushed D slot enters EX as a bubble.
  always_comb begin
    ex_d = '0;
    if (bus.id_valid_i && !stall && !bus.flush_i) begin
      ex_d.valid    = 1'b1;
      ex_d.rd       = bus.id_rd_i;
      ex_d.regwrite = bus.id_regwrite_i;
      ex_d.memread  = bus.id_memread_i;
    end
    m_d = ex_q;
    w_d = m_q;
  end

  // Tracking pipe registers; advance every clock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_q <= '0;
      m_q  <= '0;
      w_q  <= '0;
    end else begin
      ex_q <= ex_d;
      m_q  <= m_d;
      w_q  <= w_d;
    end
  end

`ifdef BRANCH_FWD_STATS_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic [31:0] fwd_cnt_d,   fwd_cnt_q;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if ((code != FWD_NONE) && (fwd_cnt_q != '1)) begin
      fwd_cnt_d = fwd_cnt_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign fwd_cnt_o   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_branch_fwd_ctrl.sv
// Self-checking bench for branch_fwd_ctrl: directed hazard scenarios followed
// by randomized traffic, all compared against a youngest-producer model.
module tb_branch_fwd_ctrl;
  import branch_fwd_pkg::*;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  branch_fwd_ctrl_if bus ();

`ifdef BRANCH_FWD_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] fwd_cnt;
`endif

  branch_fwd_ctrl dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
`ifdef BRANCH_FWD_STATS_EN
    ,
    .stall_cnt_o (stall_cnt),
    .fwd_cnt_o   (fwd_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: instructions that entered EX, newest first (age 1 = EX, 2 = M, 3 = W).
  typedef struct {
    bit valid;
    int rd;
    bit rw;
    bit ld;
  } slot_t;

  slot_t hist[3];
  int    code_tab[9];
  bit    last_st;
  longint m_stall_cnt;
  longint m_fwd_cnt;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 3; i++) hist[i] = '{valid: 1'b0, rd: 0, rw: 1'b0, ld: 1'b0};
    m_stall_cnt = 0;
    m_fwd_cnt   = 0;
  endfunction

  // Age of the youngest in-flight writer of r, 0 when none (x0 never has one).
  function automatic int youngest(int r);
    if (r == 0) return 0;
    for (int age = 1; age <= 3; age++) begin
      if (hist[age-1].valid && hist[age-1].rw && hist[age-1].rd == r) return age;
    end
    return 0;
  endfunction

  task automatic model_outputs(output bit st, output int code);
    int a_age, b_age, sa, sb;
    st = 1'b0;
    code = 0;
    if (!(bus.id_valid_i && bus.id_branch_i)) return;
    a_age = youngest(int'(bus.id_rs1_i));
    b_age = youngest(int'(bus.id_rs2_i));
    // Producer still in EX, or a load still in M: value not yet reachable.
    if (a_age == 1 || b_age == 1 ||
        (a_age == 2 && hist[1].ld) || (b_age == 2 && hist[1].ld)) begin
      st = 1'b1;
      return;
    end
    sa = (a_age == 0) ? 0 : a_age - 1;
    sb = (b_age == 0) ? 0 : b_age - 1;
    code = code_tab[sa*3 + sb];
  endtask

  task automatic drv(bit v, bit br, int rs1, int rs2, int rd, bit rw, bit ld, bit fl);
    bus.id_valid_i    = v;
    bus.id_branch_i   = br;
    bus.id_rs1_i      = rs1[REG_AW-1:0];
    bus.id_rs2_i      = rs2[REG_AW-1:0];
    bus.id_rd_i       = rd[REG_AW-1:0];
    bus.id_regwrite_i = rw;
    bus.id_memread_i  = ld;
    bus.flush_i       = fl;
  endtask

  task automatic nop();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One clock: check at negedge (optionally also against fixed values; -1 = none),
  // then advance the model on the posedge. Returns 1 time unit after the posedge.
  task automatic cycle_exp(int est, int ecode);
    bit st;
    int code;
    @(negedge clk_i);
    model_outputs(st, code);
    chk("stall", 32'(bus.stall_o), 32'(st));
    chk("opfwd", 32'(bus.opforward_o), 32'(code));
    if (est >= 0)   chk("dir_stall", 32'(bus.stall_o), 32'(est));
    if (ecode >= 0) chk("dir_opfwd", 32'(bus.opforward_o), 32'(ecode));
`ifdef BRANCH_FWD_STATS_EN
    chk("stall_cnt", stall_cnt, 32'(m_stall_cnt));
    chk("fwd_cnt",   fwd_cnt,   32'(m_fwd_cnt));
`endif
    last_st = st;
    @(posedge clk_i);
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0].valid = bus.id_valid_i && !st && !bus.flush_i;
    hist[0].rd    = int'(bus.id_rd_i);
    hist[0].rw    = bus.id_regwrite_i;
    hist[0].ld    = bus.id_memread_i;
    if (st && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
    if (code != 0 && m_fwd_cnt < 64'hFFFF_FFFF) m_fwd_cnt++;
    #1;
  endtask

  task automatic cycle();
    cycle_exp(-1, -1);
  endtask

  task automatic drain();
    nop();
    repeat (3) cycle();
  endtask

  initial begin
    code_tab = '{0, 4, 8, 3, 1, 10, 5, 9, 2};
    model_clear();
    last_st = 1'b0;

    // Reset state, even with a branch presented.
    drv(1, 1, 5, 6, 0, 0, 0, 0);
    #3;
    chk("rst_stall", 32'(bus.stall_o), 32'd0);
    chk("rst_opfwd", 32'(bus.opforward_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    nop();
    cycle();

    // ALU producer right before branch: 1 stall, then A from M.
    drv(1, 0, 0, 0, 5, 1, 0, 0); cycle_exp(0, 0);
    drv(1, 1, 5, 0, 0, 0, 0, 0); cycle_exp(1, 0); cycle_exp(0, 3);
    drain();

    // Load producer: 2 stalls, then B from W.
    drv(1, 0, 0, 0, 6, 1, 1, 0); cycle_exp(0, 0);
    drv(1, 1, 0, 6, 0, 0, 0, 0); cycle_exp(1, 0); cycle_exp(1, 0); cycle_exp(0, 8);
    drain();

    // A from M (x8), B from W (x7).
    drv(1, 0, 0, 0, 7, 1, 0, 0); cycle_exp(0, 0);
    drv(1, 0, 0, 0, 8, 1, 0, 0); cycle_exp(0, 0);
    nop();                       cycle_exp(0, 0);
    drv(1, 1, 8, 7, 0, 0, 0, 0); cycle_exp(0, 10);
    drain();

    // Same register in M and W: M wins.
    drv(1, 0, 0, 0, 9, 1, 0, 0); cycle_exp(0, 0);
    drv(1, 0, 0, 0, 9, 1, 0, 0); cycle_exp(0, 0);
    nop();                       cycle_exp(0, 0);
    drv(1, 1, 9, 9, 0, 0, 0, 0); cycle_exp(0, 1);
    drain();

    // x0 is never a hazard.
    drv(1, 0, 0, 0, 0, 1, 0, 0); cycle_exp(0, 0);
    drv(1, 1, 0, 0, 0, 0, 0, 0); cycle_exp(0, 0);
    drain();

    // Flushed producer never enters the pipe.
    drv(1, 0, 0, 0, 5, 1, 0, 1); cycle_exp(0, 0);
    drv(1, 1, 5, 5, 0, 0, 0, 0); cycle_exp(0, 0);
    nop();                       cycle_exp(0, 0);
    cycle_exp(0, 0);
    drain();

    // Flush while stalled: still a bubble.
    drv(1, 0, 0, 0, 4, 1, 0, 0); cycle_exp(0, 0);
    drv(1, 1, 4, 4, 0, 0, 0, 1); cycle_exp(1, 0);
    drv(1, 1, 4, 4, 0, 0, 0, 0); cycle_exp(0, 1);
    drain();

    // Reset asserted mid load-stall: outputs drop at once, pipe restarts empty.
    drv(1, 0, 0, 0, 6, 1, 1, 0); cycle_exp(0, 0);
    drv(1, 1, 0, 6, 0, 0, 0, 0); cycle_exp(1, 0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_stall", 32'(bus.stall_o), 32'd0);
    chk("rst_mid_opfwd", 32'(bus.opforward_o), 32'd0);
    model_clear();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    cycle_exp(0, 0);
    drain();

    // Randomized traffic over a small register window; D holds while stalled.
    for (int i = 0; i < 500; i++) begin
      if (last_st) begin
        bus.flush_i = ($urandom_range(0, 9) == 0);
      end else begin
        drv(($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
